// File: rtl/pu_operand_feeder.sv
// rtl/pu_operand_feeder.sv - operand-pair sequencer feeding process_unit
//
// Purpose:
//   Holds up to DEPTH operand pairs loaded by the layer controller. On start it
//   issues the pairs to process_unit as a/b with one-cycle fetch_enable pulses
//   spaced GAP idle cycles apart, then pulses finish_enable, waits FINISH_LAT
//   cycles and captures sum_in into result with a one-cycle result_valid.
//
// Ports:
//   m_clk          in   1           sole clock, rising edge
//   rst            in   1           synchronous, active-low reset
//   wr_en          in   1           buffer write strobe (honoured only when idle)
//   wr_addr        in   ADDR_W      buffer write address
//   wr_a, wr_b     in   DATA_W      operand pair to store
//   len            in   ADDR_W+1    pairs to issue, sampled with start
//   start          in   1           begin a run (idle only, len != 0)
//   sum_in         in   DATA_W      process_unit sum
//   a, b           out  DATA_W      operands to process_unit
//   fetch_enable   out  1           operand-valid pulse
//   finish_enable  out  1           end-of-vector pulse
//   busy           out  1           run in progress
//   result         out  DATA_W      captured sum, held until the next run ends
//   result_valid   out  1           one-cycle pulse, result is valid

module pu_operand_feeder #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP        = 6,
  parameter int FINISH_LAT = 2
) (
  input  logic              m_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_a,
  input  logic [DATA_W-1:0] wr_b,
  input  logic [ADDR_W:0]   len,
  input  logic              start,
  input  logic [DATA_W-1:0] sum_in,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              fetch_enable,
  output logic              finish_enable,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_valid
);

  localparam int CNT_MAX = (GAP > FINISH_LAT) ? GAP : FINISH_LAT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(FINISH_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP_WAIT,
    S_FINISH,
    S_DRAIN,
    S_DONE
  } state_t;

  // Operand buffer: deliberately not reset so contents survive rst.
  logic [DATA_W-1:0] r_mem_a [DEPTH];
  logic [DATA_W-1:0] r_mem_b [DEPTH];

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_idx;
  logic [ADDR_W:0]   r_len;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_fetch;
  logic              r_finish;
  logic              r_busy;
  logic [DATA_W-1:0] r_result;
  logic              r_result_valid;

  logic              w_wr_fire;
  logic              w_start_ok;
  logic [ADDR_W:0]   w_len_sat;
  logic [ADDR_W:0]   w_rd_idx;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic [ADDR_W:0]   w_idx_nxt;
  logic [ADDR_W:0]   w_len_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_fetch_nxt;
  logic              w_finish_nxt;
  logic              w_busy_nxt;
  logic              w_result_valid_nxt;
  logic              w_capture;

  assign w_wr_fire  = wr_en && (r_state == S_IDLE) && ({1'b0, wr_addr} < DEPTH_L);
  assign w_start_ok = start && (r_state == S_IDLE) && (len != '0);
  assign w_len_sat  = (len > DEPTH_L) ? DEPTH_L : len;

  always_ff @(posedge m_clk) begin
    if (w_wr_fire) begin
      r_mem_a[wr_addr] <= wr_a;
      r_mem_b[wr_addr] <= wr_b;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge m_clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_len          <= '0;
      r_cnt          <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_fetch        <= 1'b0;
      r_finish       <= 1'b0;
      r_busy         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_idx          <= w_idx_nxt;
      r_len          <= w_len_nxt;
      r_cnt          <= w_cnt_nxt;
      r_fetch        <= w_fetch_nxt;
      r_finish       <= w_finish_nxt;
      r_busy         <= w_busy_nxt;
      r_result_valid <= w_result_valid_nxt;
      if (w_fetch_nxt) begin
        r_a <= w_rd_a;
        r_b <= w_rd_b;
      end
      if (w_capture) begin
        r_result <= sum_in;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_GAP_WAIT;
      end
      S_GAP_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = (r_idx < r_len) ? S_LOAD : S_FINISH;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output / datapath next values. Outputs are decoded from the next state so
  // that each pulse is registered and lands in the cycle of the state it marks.
  always_comb begin
    w_fetch_nxt        = (w_state_nxt == S_LOAD);
    w_finish_nxt       = (w_state_nxt == S_FINISH);
    w_busy_nxt         = (w_state_nxt != S_IDLE);
    w_result_valid_nxt = (w_state_nxt == S_DONE);
    w_capture          = (r_state == S_DRAIN) && (w_state_nxt == S_DONE);

    // A run always starts from pair 0, whatever idx was left at.
    w_rd_idx  = (r_state == S_IDLE) ? '0 : r_idx;
    w_rd_addr = w_rd_idx[ADDR_W-1:0];

    // Bypass a write landing on the same edge as start so the run sees it.
    if (w_wr_fire && (wr_addr == w_rd_addr)) begin
      w_rd_a = wr_a;
      w_rd_b = wr_b;
    end else begin
      w_rd_a = r_mem_a[w_rd_addr];
      w_rd_b = r_mem_b[w_rd_addr];
    end

    w_idx_nxt = r_idx;
    if (w_state_nxt == S_LOAD) begin
      w_idx_nxt = w_rd_idx + 1'b1;
    end

    w_len_nxt = r_len;
    if (w_start_ok) begin
      w_len_nxt = w_len_sat;
    end

    w_cnt_nxt = '0;
    case (r_state)
      S_LOAD:     w_cnt_nxt = GAP_LD;
      S_GAP_WAIT: w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
      S_FINISH:   w_cnt_nxt = DRAIN_LD;
      S_DRAIN:    w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
      default:    w_cnt_nxt = '0;
    endcase
  end

  assign a             = r_a;
  assign b             = r_b;
  assign fetch_enable  = r_fetch;
  assign finish_enable = r_finish;
  assign busy          = r_busy;
  assign result        = r_result;
  assign result_valid  = r_result_valid;

endmodule

// File: tb/tb_pu_operand_feeder.sv
// tb/tb_pu_operand_feeder.sv - directed self-checking bench for pu_operand_feeder
//
// Purpose:
//   Drives directed runs into pu_operand_feeder, models process_unit as a
//   multiply-accumulate on fetch_enable that publishes its sum on
//   finish_enable, and checks pulse timing, operands and captured result.
//
// Ports: none (top-level bench).

module tb_pu_operand_feeder;

  localparam int GAP     = 6;
  localparam int FIN_LAT = 2;
  localparam int PERIOD  = GAP + 1;

  logic        m_clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_a = '0;
  logic [15:0] wr_b = '0;
  logic [4:0]  len = '0;
  logic        start = 1'b0;
  logic [15:0] sum_in;
  logic [15:0] a;
  logic [15:0] b;
  logic        fetch_enable;
  logic        finish_enable;
  logic        busy;
  logic [15:0] result;
  logic        result_valid;

  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];
  logic [15:0] acc;

  int n_checks = 0;
  int n_fail   = 0;

  pu_operand_feeder #(
    .DATA_W(16), .DEPTH(16), .ADDR_W(4), .GAP(GAP), .FINISH_LAT(FIN_LAT)
  ) dut (
    .m_clk(m_clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_a(wr_a), .wr_b(wr_b), .len(len), .start(start), .sum_in(sum_in),
    .a(a), .b(b), .fetch_enable(fetch_enable), .finish_enable(finish_enable),
    .busy(busy), .result(result), .result_valid(result_valid)
  );

  always #5 m_clk = ~m_clk;

  // process_unit stand-in: accumulate a*b, publish on finish.
  always @(posedge m_clk) begin
    if (!rst) begin
      acc    <= '0;
      sum_in <= '0;
    end else if (fetch_enable) begin
      acc <= acc + a * b;
    end else if (finish_enable) begin
      sum_in <= acc;
      acc    <= '0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_pair(input int addr, input int va, input int vb);
    @(negedge m_clk);
    wr_en   = 1'b1;
    wr_addr = addr[3:0];
    wr_a    = va[15:0];
    wr_b    = vb[15:0];
    mem_a[addr] = va[15:0];
    mem_b[addr] = vb[15:0];
    @(negedge m_clk);
    wr_en = 1'b0;
  endtask

  // start sampled at the end of cycle 0; cycles 1..last+1 are checked.
  task automatic run_check(input string name, input int len_v, input int nl,
                           input int exp_sum, input bit inj,
                           input bit sw, input int swa, input int swb);
    int last, k, fe, fi, bz, rv;
    last = 2 + nl * PERIOD + FIN_LAT;
    @(negedge m_clk);
    start = 1'b1;
    len   = len_v[4:0];
    if (sw) begin
      wr_en    = 1'b1;
      wr_addr  = 4'd0;
      wr_a     = swa[15:0];
      wr_b     = swb[15:0];
      mem_a[0] = swa[15:0];
      mem_b[0] = swb[15:0];
    end
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge m_clk);
      start = 1'b0;
      wr_en = 1'b0;
      fe = ((c - 1) % PERIOD == 0) && ((c - 1) / PERIOD < nl) ? 1 : 0;
      fi = (c == 1 + nl * PERIOD) ? 1 : 0;
      rv = (c == last) ? 1 : 0;
      bz = (c <= last) ? 1 : 0;
      check($sformatf("%s c%0d ctl", name, c),
            {28'd0, fetch_enable, finish_enable, busy, result_valid},
            32'(fe * 8 + fi * 4 + bz * 2 + rv));
      k = (c - 1) / PERIOD;
      if (k > nl - 1) k = nl - 1;
      check($sformatf("%s c%0d a", name, c), {16'd0, a}, {16'd0, mem_a[k]});
      check($sformatf("%s c%0d b", name, c), {16'd0, b}, {16'd0, mem_b[k]});
      if (c >= last) begin
        check($sformatf("%s c%0d result", name, c), {16'd0, result}, 32'(exp_sum));
      end
      if (inj && c == 3) begin
        start   = 1'b1;
        len     = len_v[4:0];
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_a    = 16'd9;
        wr_b    = 16'd9;
      end
    end
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    // Reset state.
    rst = 1'b0;
    repeat (3) @(negedge m_clk);
    check("rst ctl", {28'd0, fetch_enable, finish_enable, busy, result_valid}, 32'd0);
    check("rst a", {16'd0, a}, 32'd0);
    check("rst b", {16'd0, b}, 32'd0);
    check("rst result", {16'd0, result}, 32'd0);
    rst = 1'b1;

    // Basic two-pair run: 2*3 + 3*5 = 21.
    write_pair(0, 2, 3);
    write_pair(1, 3, 5);
    run_check("basic", 2, 2, 21, 1'b0, 1'b0, 0, 0);

    // start and wr_en at address 0 in cycle 3 are ignored.
    run_check("ignored", 2, 2, 21, 1'b1, 1'b0, 0, 0);
    run_check("after_ignored", 2, 2, 21, 1'b0, 1'b0, 0, 0);

    // Reset in cycle 9 of a run.
    @(negedge m_clk);
    start = 1'b1;
    len   = 5'd2;
    @(negedge m_clk);
    start = 1'b0;
    repeat (8) @(negedge m_clk);
    rst = 1'b0;
    @(negedge m_clk);
    check("midrst ctl", {28'd0, fetch_enable, finish_enable, busy, result_valid}, 32'd0);
    check("midrst a", {16'd0, a}, 32'd0);
    check("midrst b", {16'd0, b}, 32'd0);
    check("midrst result", {16'd0, result}, 32'd0);
    rst = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge m_clk);
      check($sformatf("postrst c%0d busy_rv", c), {30'd0, busy, result_valid}, 32'd0);
    end
    run_check("rerun", 2, 2, 21, 1'b0, 1'b0, 0, 0);

    // Full buffer (i, i+1): sum of i*(i+1) for i=0..15 is 1360.
    for (int i = 0; i < 16; i++) write_pair(i, i, i + 1);
    run_check("full", 16, 16, 1360, 1'b0, 1'b0, 0, 0);
    run_check("sat31", 31, 16, 1360, 1'b0, 1'b0, 0, 0);

    // Zero length: nothing happens, result keeps its last value.
    @(negedge m_clk);
    start = 1'b1;
    len   = 5'd0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge m_clk);
      start = 1'b0;
      check($sformatf("zero c%0d ctl", c),
            {28'd0, fetch_enable, finish_enable, busy, result_valid}, 32'd0);
    end
    check("zero result hold", {16'd0, result}, 32'd1360);

    // Write to address 0 in the start cycle is used by the run: 7*4 = 28.
    run_check("same_cycle", 1, 1, 28, 1'b0, 1'b1, 7, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
